// File: rtl/rr_free_list_pkg.sv
// Shared sizing, types and reset helper for the physical-register free list.
// No logic of its own; pure compile-time constants and typedefs.
// Imported by the interface, the checkpoint table and the free-list top.
package rr_free_list_pkg;

  localparam int P_REGISTERS   = 64;
  localparam int L_REGS        = 8;
  localparam int C_NUM         = 4;
  localparam int P_ADDR_WIDTH  = $clog2(P_REGISTERS);
  localparam int FL_PTR_WIDTH  = P_ADDR_WIDTH + 1;
  localparam int CKPT_ID_WIDTH = $clog2(C_NUM);
  localparam int FL_INIT_COUNT = P_REGISTERS - L_REGS;

  typedef logic [P_ADDR_WIDTH-1:0]  preg_t;
  typedef logic [FL_PTR_WIDTH-1:0]  free_list_ckpt_t;
  typedef logic [CKPT_ID_WIDTH-1:0] ckpt_id_t;

  // Reset content of slot i: pregs L_REGS.. fill the live part of the list;
  // the slots past the live region wrap around to the architectural pregs,
  // which are never read before being overwritten by a release.
  function automatic preg_t fl_init_entry(input int i);
    return preg_t'(L_REGS + i);
  endfunction

endpackage

// File: rtl/rr_free_list_if.sv
// Rename-stage <-> free-list handshake bundle (alloc, checkpoint, release, flush).
// Purely wiring; no latency of its own.
// Renamer must only assert allocation enables while alloc_ready is high.
interface rr_free_list_if import rr_free_list_pkg::*; ();

  logic            alloc_ready;
  logic            alloc_en_1;
  logic            alloc_en_2;
  preg_t           preg_1;
  preg_t           preg_2;
  logic            ckpt_en;
  ckpt_id_t        ckpt_id;
  logic            release_en;
  preg_t           release_preg;
  logic            flush_valid;
  ckpt_id_t        flush_rat_id;
  free_list_ckpt_t free_count;

  // Renamer / commit / branch-unit side.
  modport master (
    input  alloc_ready, preg_1, preg_2, free_count,
    output alloc_en_1, alloc_en_2, ckpt_en, ckpt_id,
           release_en, release_preg, flush_valid, flush_rat_id
  );

  // Free-list side.
  modport slave (
    output alloc_ready, preg_1, preg_2, free_count,
    input  alloc_en_1, alloc_en_2, ckpt_en, ckpt_id,
           release_en, release_preg, flush_valid, flush_rat_id
  );

endinterface

// File: rtl/rr_ckpt_table.sv
// C_NUM-entry table of saved allocation pointers, one per in-flight branch.
// Write lands in one cycle; read port is combinational from the flops.
// No backpressure: a write to a slot simply overwrites the older pointer.
module rr_ckpt_table import rr_free_list_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  ckpt_id_t        wr_id,
  input  free_list_ckpt_t wr_ptr,
  input  ckpt_id_t        rd_id,
  output free_list_ckpt_t rd_ptr
);

  free_list_ckpt_t ckpt_q [C_NUM];
  free_list_ckpt_t ckpt_d [C_NUM];

  // Next-state: overwrite the addressed slot when a checkpoint is taken.
  always_comb begin
    ckpt_d = ckpt_q;
    if (wr_en) begin
      ckpt_d[wr_id] = wr_ptr;
    end
  end

  // State update; reset clears every slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < C_NUM; i++) begin
        ckpt_q[i] <= '0;
      end
    end else begin
      ckpt_q <= ckpt_d;
    end
  end

  assign rd_ptr = ckpt_q[rd_id];

endmodule

// File: rtl/rr_free_list.sv
// Physical-register free list: two allocs + one release per cycle, checkpointed head.
// Pointer/array updates take one cycle; preg_1/preg_2 are read straight from the array.
// alloc_ready (>=2 free) gates allocation; flush overrides allocs and checkpoints.
module rr_free_list import rr_free_list_pkg::*; (
  input  logic          clk,
  input  logic          rst,
  rr_free_list_if.slave fl
);

  preg_t           fl_q [P_REGISTERS];
  preg_t           fl_d [P_REGISTERS];
  free_list_ckpt_t rd_ptr_q, rd_ptr_d;
  free_list_ckpt_t wr_ptr_q, wr_ptr_d;
  free_list_ckpt_t rd_nxt;
  free_list_ckpt_t ckpt_rd_ptr;
  free_list_ckpt_t free_count;
  preg_t           rd_idx_1, rd_idx_2;
  logic [1:0]      pop;
  logic            alloc_ready;
  logic            alloc_ok;

  // Occupancy is derived purely from the pointer flops, so alloc_ready has no
  // combinational path from any input.
  assign free_count  = wr_ptr_q - rd_ptr_q;
  assign alloc_ready = (free_count >= free_list_ckpt_t'(2));

  assign rd_idx_1 = rd_ptr_q[P_ADDR_WIDTH-1:0];
  assign rd_idx_2 = rd_idx_1 + preg_t'(1);

  assign fl.preg_1      = fl_q[rd_idx_1];
  assign fl.preg_2      = fl_q[rd_idx_2];
  assign fl.free_count  = free_count;
  assign fl.alloc_ready = alloc_ready;

  // Head advance: a flush wins over same-cycle allocations; the pointer after
  // this cycle's allocations is also what a checkpoint captures, so the
  // branch's own destination survives its recovery.
  always_comb begin
    pop      = {1'b0, fl.alloc_en_1} + {1'b0, fl.alloc_en_2};
    alloc_ok = alloc_ready && !fl.flush_valid;
    rd_nxt   = rd_ptr_q + (alloc_ok ? free_list_ckpt_t'(pop) : '0);
    rd_ptr_d = fl.flush_valid ? ckpt_rd_ptr : rd_nxt;
  end

  // Tail push: releases are applied even during a flush; no bypass to the head.
  always_comb begin
    fl_d     = fl_q;
    wr_ptr_d = wr_ptr_q;
    if (fl.release_en) begin
      fl_d[wr_ptr_q[P_ADDR_WIDTH-1:0]] = fl.release_preg;
      wr_ptr_d = wr_ptr_q + free_list_ckpt_t'(1);
    end
  end

  // State update; reset reloads the list with every non-architectural preg.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= free_list_ckpt_t'(FL_INIT_COUNT);
      for (int i = 0; i < P_REGISTERS; i++) begin
        fl_q[i] <= fl_init_entry(i);
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      fl_q     <= fl_d;
    end
  end

  rr_ckpt_table u_ckpt_table (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (fl.ckpt_en && !fl.flush_valid),
    .wr_id  (fl.ckpt_id),
    .wr_ptr (rd_nxt),
    .rd_id  (fl.flush_rat_id),
    .rd_ptr (ckpt_rd_ptr)
  );

  // Renamer must not allocate from a list that cannot cover a full dual pop.
  a_alloc_only_when_ready : assert property (
    @(posedge clk) disable iff (rst) (fl.alloc_en_1 || fl.alloc_en_2) |-> alloc_ready);

  // The second slot is only ever consumed together with the first.
  a_en2_needs_en1 : assert property (
    @(posedge clk) disable iff (rst) fl.alloc_en_2 |-> fl.alloc_en_1);

  // A release into a completely full list means a preg was freed twice.
  a_no_double_free : assert property (
    @(posedge clk) disable iff (rst)
    fl.release_en |-> (free_count != free_list_ckpt_t'(P_REGISTERS)))
    else $fatal(1, "rr_free_list: release into a full free list (double free)");

endmodule

// File: tb/tb_rr_free_list.sv
// Self-checking bench for rr_free_list: directed reset/drain/release/flush scenarios
// followed by a random alloc/release run checked against a queue model of the list.
// Inputs are driven and outputs sampled on the falling edge.
module tb_rr_free_list;
  import rr_free_list_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rr_free_list_if fl_if ();

  rr_free_list u_dut (
    .clk (clk),
    .rst (rst),
    .fl  (fl_if)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  preg_t exp_q[$];
  bit    out_q[P_REGISTERS];

  task automatic drive_idle();
    fl_if.alloc_en_1   = 1'b0;
    fl_if.alloc_en_2   = 1'b0;
    fl_if.ckpt_en      = 1'b0;
    fl_if.ckpt_id      = '0;
    fl_if.release_en   = 1'b0;
    fl_if.release_preg = '0;
    fl_if.flush_valid  = 1'b0;
    fl_if.flush_rat_id = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (fl_if.preg_1 !== preg_t'(8)) begin
      errors++; $display("FAIL reset_preg_1: got %0d expected 8", fl_if.preg_1);
    end
    checks++;
    if (fl_if.preg_2 !== preg_t'(9)) begin
      errors++; $display("FAIL reset_preg_2: got %0d expected 9", fl_if.preg_2);
    end
    checks++;
    if (fl_if.free_count !== free_list_ckpt_t'(56)) begin
      errors++; $display("FAIL reset_free_count: got %0d expected 56", fl_if.free_count);
    end
    checks++;
    if (fl_if.alloc_ready !== 1'b1) begin
      errors++; $display("FAIL reset_alloc_ready: got %0b expected 1", fl_if.alloc_ready);
    end
  endtask

  // 28 dual allocations empty the list; pregs must come out 8..63 in order.
  task automatic test_drain();
    exp_q.delete();
    for (int v = 8; v < 64; v++) exp_q.push_back(preg_t'(v));
    for (int i = 0; i < 28; i++) begin
      preg_t e1, e2;
      e1 = exp_q.pop_front();
      e2 = exp_q.pop_front();
      checks++;
      if (fl_if.preg_1 !== e1) begin
        errors++; $display("FAIL drain_preg_1[%0d]: got %0d expected %0d", i, fl_if.preg_1, e1);
      end
      checks++;
      if (fl_if.preg_2 !== e2) begin
        errors++; $display("FAIL drain_preg_2[%0d]: got %0d expected %0d", i, fl_if.preg_2, e2);
      end
      checks++;
      if (fl_if.free_count !== free_list_ckpt_t'(56 - 2 * i)) begin
        errors++; $display("FAIL drain_free_count[%0d]: got %0d expected %0d", i, fl_if.free_count, 56 - 2 * i);
      end
      fl_if.alloc_en_1 = 1'b1;
      fl_if.alloc_en_2 = 1'b1;
      @(negedge clk);
    end
    drive_idle();
    checks++;
    if (fl_if.free_count !== free_list_ckpt_t'(0)) begin
      errors++; $display("FAIL drain_empty_count: got %0d expected 0", fl_if.free_count);
    end
    checks++;
    if (fl_if.alloc_ready !== 1'b0) begin
      errors++; $display("FAIL drain_empty_ready: got %0b expected 0", fl_if.alloc_ready);
    end
  endtask

  // From empty, two releases refill the head in order.
  task automatic test_release_from_empty();
    fl_if.release_en   = 1'b1;
    fl_if.release_preg = preg_t'(5);
    @(negedge clk);
    checks++;
    if (fl_if.free_count !== free_list_ckpt_t'(1)) begin
      errors++; $display("FAIL release_count_1: got %0d expected 1", fl_if.free_count);
    end
    checks++;
    if (fl_if.alloc_ready !== 1'b0) begin
      errors++; $display("FAIL release_ready_1: got %0b expected 0", fl_if.alloc_ready);
    end
    fl_if.release_preg = preg_t'(12);
    @(negedge clk);
    drive_idle();
    checks++;
    if (fl_if.free_count !== free_list_ckpt_t'(2)) begin
      errors++; $display("FAIL release_count_2: got %0d expected 2", fl_if.free_count);
    end
    checks++;
    if (fl_if.alloc_ready !== 1'b1) begin
      errors++; $display("FAIL release_ready_2: got %0b expected 1", fl_if.alloc_ready);
    end
    checks++;
    if (fl_if.preg_1 !== preg_t'(5)) begin
      errors++; $display("FAIL release_preg_1: got %0d expected 5", fl_if.preg_1);
    end
    checks++;
    if (fl_if.preg_2 !== preg_t'(12)) begin
      errors++; $display("FAIL release_preg_2: got %0d expected 12", fl_if.preg_2);
    end
  endtask

  // Checkpoint taken with the first dual alloc; flush rewinds to just after it.
  task automatic test_checkpoint_flush();
    apply_reset();
    fl_if.alloc_en_1 = 1'b1;
    fl_if.alloc_en_2 = 1'b1;
    fl_if.ckpt_en    = 1'b1;
    fl_if.ckpt_id    = ckpt_id_t'(2);
    @(negedge clk);
    fl_if.ckpt_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    drive_idle();
    checks++;
    if (fl_if.preg_1 !== preg_t'(14)) begin
      errors++; $display("FAIL ckpt_pre_flush_preg_1: got %0d expected 14", fl_if.preg_1);
    end
    checks++;
    if (fl_if.free_count !== free_list_ckpt_t'(50)) begin
      errors++; $display("FAIL ckpt_pre_flush_count: got %0d expected 50", fl_if.free_count);
    end
    fl_if.flush_valid  = 1'b1;
    fl_if.flush_rat_id = ckpt_id_t'(2);
    @(negedge clk);
    drive_idle();
    checks++;
    if (fl_if.preg_1 !== preg_t'(10)) begin
      errors++; $display("FAIL flush_preg_1: got %0d expected 10", fl_if.preg_1);
    end
    checks++;
    if (fl_if.preg_2 !== preg_t'(11)) begin
      errors++; $display("FAIL flush_preg_2: got %0d expected 11", fl_if.preg_2);
    end
    checks++;
    if (fl_if.free_count !== free_list_ckpt_t'(54)) begin
      errors++; $display("FAIL flush_free_count: got %0d expected 54", fl_if.free_count);
    end
  endtask

  // Flush, dual alloc and release in one cycle: alloc dropped, release kept.
  task automatic test_flush_same_cycle();
    fl_if.alloc_en_1 = 1'b1;
    fl_if.alloc_en_2 = 1'b1;
    fl_if.ckpt_en    = 1'b1;
    fl_if.ckpt_id    = ckpt_id_t'(1);
    @(negedge clk);
    fl_if.ckpt_en = 1'b0;
    @(negedge clk);
    fl_if.flush_valid  = 1'b1;
    fl_if.flush_rat_id = ckpt_id_t'(1);
    fl_if.release_en   = 1'b1;
    fl_if.release_preg = preg_t'(3);
    @(negedge clk);
    drive_idle();
    checks++;
    if (fl_if.preg_1 !== preg_t'(12)) begin
      errors++; $display("FAIL same_cycle_preg_1: got %0d expected 12", fl_if.preg_1);
    end
    checks++;
    if (fl_if.free_count !== free_list_ckpt_t'(53)) begin
      errors++; $display("FAIL same_cycle_count: got %0d expected 53", fl_if.free_count);
    end
    for (int i = 0; i < 26; i++) begin
      checks++;
      if (fl_if.preg_1 !== preg_t'(12 + 2 * i)) begin
        errors++; $display("FAIL tail_drain_preg_1[%0d]: got %0d expected %0d", i, fl_if.preg_1, 12 + 2 * i);
      end
      fl_if.alloc_en_1 = 1'b1;
      fl_if.alloc_en_2 = 1'b1;
      @(negedge clk);
    end
    drive_idle();
    fl_if.release_en   = 1'b1;
    fl_if.release_preg = preg_t'(40);
    @(negedge clk);
    drive_idle();
    checks++;
    if (fl_if.alloc_ready !== 1'b1) begin
      errors++; $display("FAIL tail_ready: got %0b expected 1", fl_if.alloc_ready);
    end
    checks++;
    if (fl_if.preg_1 !== preg_t'(3)) begin
      errors++; $display("FAIL tail_preg_1: got %0d expected 3", fl_if.preg_1);
    end
    checks++;
    if (fl_if.preg_2 !== preg_t'(40)) begin
      errors++; $display("FAIL tail_preg_2: got %0d expected 40", fl_if.preg_2);
    end
  endtask

  // Random allocs/releases long enough to wrap both pointers past 2*P_REGISTERS.
  task automatic test_wrap_random();
    apply_reset();
    exp_q.delete();
    for (int v = 0; v < P_REGISTERS; v++) out_q[v] = (v < L_REGS);
    for (int v = L_REGS; v < P_REGISTERS; v++) exp_q.push_back(preg_t'(v));
    for (int cyc = 0; cyc < 400; cyc++) begin
      int    pop;
      int    cand[$];
      preg_t got;
      checks++;
      if (fl_if.free_count !== free_list_ckpt_t'(exp_q.size())) begin
        errors++; $display("FAIL rand_free_count[%0d]: got %0d expected %0d", cyc, fl_if.free_count, exp_q.size());
      end
      checks++;
      if (fl_if.alloc_ready !== (exp_q.size() >= 2)) begin
        errors++; $display("FAIL rand_alloc_ready[%0d]: got %0b expected %0b", cyc, fl_if.alloc_ready, exp_q.size() >= 2);
      end
      pop = (exp_q.size() >= 2) ? int'($urandom_range(0, 2)) : 0;
      drive_idle();
      if (pop >= 1) begin
        got = fl_if.preg_1;
        checks++;
        if (got !== exp_q[0] || out_q[got]) begin
          errors++; $display("FAIL rand_preg_1[%0d]: got %0d expected %0d (outstanding=%0b)", cyc, got, exp_q[0], out_q[got]);
        end
        out_q[exp_q.pop_front()] = 1'b1;
        fl_if.alloc_en_1 = 1'b1;
      end
      if (pop == 2) begin
        got = fl_if.preg_2;
        checks++;
        if (got !== exp_q[0] || out_q[got]) begin
          errors++; $display("FAIL rand_preg_2[%0d]: got %0d expected %0d (outstanding=%0b)", cyc, got, exp_q[0], out_q[got]);
        end
        out_q[exp_q.pop_front()] = 1'b1;
        fl_if.alloc_en_2 = 1'b1;
      end
      for (int v = 0; v < P_REGISTERS; v++) if (out_q[v]) cand.push_back(v);
      if (cand.size() > 0 && $urandom_range(0, 3) != 0) begin
        int idx;
        idx = int'($urandom_range(0, cand.size() - 1));
        out_q[cand[idx]] = 1'b0;
        exp_q.push_back(preg_t'(cand[idx]));
        fl_if.release_en   = 1'b1;
        fl_if.release_preg = preg_t'(cand[idx]);
      end
      @(negedge clk);
    end
    drive_idle();
    @(negedge clk);
    checks++;
    if (fl_if.free_count !== free_list_ckpt_t'(exp_q.size())) begin
      errors++; $display("FAIL rand_final_count: got %0d expected %0d", fl_if.free_count, exp_q.size());
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_drain();
    test_release_from_empty();
    test_checkpoint_flush();
    test_flush_same_cycle();
    test_wrap_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
